// File: rtl/fsm_event_pkg.sv
// Shared types and elaboration helpers for the FSM event recorder.
// Optional trace output in fsm_event_recorder is enabled by FSM_EVENT_RECORDER_TRACE_EN.
package fsm_event_pkg;

    localparam int unsigned STATE_W_DEF = 4;
    localparam int unsigned TS_W_DEF    = 32;

    // One recorded transition at the default widths.
    typedef struct packed {
        logic [TS_W_DEF-1:0]    ts;
        logic [STATE_W_DEF-1:0] from;
        logic [STATE_W_DEF-1:0] to;
    } fsm_event_t;

    // log2 of a legal FIFO depth (power of two, >= 2); 0 flags an illegal depth.
    function automatic int unsigned clog2_safe(input int unsigned depth);
        if (depth < 2 || (depth & (depth - 1)) != 0) begin
            return 0;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fsm_event_fifo.sv
// Single-clock FIFO of transition records with wrap-bit pointers.
// Push is accepted when not full, or when a pop happens in the same cycle.
module fsm_event_fifo
    import fsm_event_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = fsm_event_t
) (
    input  logic aclk,
    input  logic srst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data_c,
    output logic o_full_c,
    output logic o_empty_c
);

    localparam int unsigned AW = clog2_safe(DEPTH);

    if (AW == 0) begin : g_bad_depth
        $error("fsm_event_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    T            r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty_c = (r_wptr == r_rptr);
    assign o_full_c  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty_c;
    assign w_do_push = i_push & (~o_full_c | w_do_pop);
    assign o_data_c  = r_mem[r_rptr[AW-1:0]];

    // Pointer update; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge aclk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/fsm_event_recorder.sv
// Watches an FSM state bus, timestamps each transition and streams the
// records out through a FIFO on a valid/ready interface.
// Define FSM_EVENT_RECORDER_TRACE_EN for a simulation-only transition log.
module fsm_event_recorder
    import fsm_event_pkg::*;
#(
    parameter int          NAME    = 0,
    parameter int unsigned STATE_W = 4,
    parameter int unsigned TS_W    = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DROP_W  = 8
) (
    input  logic               aclk,
    input  logic               srst,
    input  logic               state_valid,
    input  logic [STATE_W-1:0] state_in,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [31:0]        evt_id,
    output logic [TS_W-1:0]    evt_ts,
    output logic [STATE_W-1:0] evt_from,
    output logic [STATE_W-1:0] evt_to,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic               overflow
);

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [STATE_W-1:0] from;
        logic [STATE_W-1:0] to;
    } rec_t;

    logic [TS_W-1:0]    r_ts;
    logic               r_primed;
    logic [STATE_W-1:0] r_prev;
    logic [DROP_W-1:0]  r_drop_cnt;
    logic               r_overflow;

    logic w_push_req;
    logic w_push_acc;
    logic w_drop;
    logic w_pop;
    logic w_full;
    logic w_empty;
    rec_t w_rec_in;
    rec_t w_rec_out;

    assign w_push_req = r_primed & state_valid & (state_in != r_prev);
    assign w_pop      = ~w_empty & evt_ready;
    assign w_push_acc = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_push_acc;
    assign w_rec_in   = '{ts: r_ts, from: r_prev, to: state_in};

    // Free-running timestamp, priming and last-seen state tracking.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_ts     <= '0;
            r_primed <= 1'b0;
            r_prev   <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (state_valid) begin
                r_primed <= 1'b1;
                r_prev   <= state_in;
            end
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    fsm_event_fifo #(
        .DEPTH (DEPTH),
        .T     (rec_t)
    ) u_fifo (
        .aclk      (aclk),
        .srst      (srst),
        .i_push    (w_push_acc),
        .i_data    (w_rec_in),
        .i_pop     (w_pop),
        .o_data_c  (w_rec_out),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    assign evt_valid = ~w_empty;
    assign evt_id    = 32'(NAME);
    assign evt_ts    = w_rec_out.ts;
    assign evt_from  = w_rec_out.from;
    assign evt_to    = w_rec_out.to;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;

`ifdef FSM_EVENT_RECORDER_TRACE_EN
    // Simulation-only log of accepted and dropped transitions.
    always @(posedge aclk) begin
        if (!srst && w_push_acc) begin
            $display("[%t] FSM%0d %0d -> %0d @%0d", $time, NAME, r_prev, state_in, r_ts);
        end
        if (!srst && w_drop) begin
            $display("WARNING: [%t] FSM%0d %0d -> %0d @%0d lost, FIFO full", $time, NAME, r_prev, state_in, r_ts);
        end
    end
`endif

endmodule

// File: tb/tb_fsm_event_recorder.sv
// Bench for fsm_event_recorder: directed scenarios plus randomized traffic
// checked against a transaction-level model (queue of records).
module tb_fsm_event_recorder;

    localparam int          NAME    = 7;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned TS_W    = 4;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DROP_W  = 8;
    localparam int unsigned TS_MOD  = 1 << TS_W;
    localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

    logic               aclk;
    logic               srst;
    logic               state_valid;
    logic [STATE_W-1:0] state_in;
    logic               evt_valid;
    logic               evt_ready;
    logic [31:0]        evt_id;
    logic [TS_W-1:0]    evt_ts;
    logic [STATE_W-1:0] evt_from;
    logic [STATE_W-1:0] evt_to;
    logic [DROP_W-1:0]  drop_cnt;
    logic               overflow;

    fsm_event_recorder #(
        .NAME    (NAME),
        .STATE_W (STATE_W),
        .TS_W    (TS_W),
        .DEPTH   (DEPTH),
        .DROP_W  (DROP_W)
    ) dut (
        .aclk        (aclk),
        .srst        (srst),
        .state_valid (state_valid),
        .state_in    (state_in),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .evt_ts      (evt_ts),
        .evt_from    (evt_from),
        .evt_to      (evt_to),
        .drop_cnt    (drop_cnt),
        .overflow    (overflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model: records as a queue, timestamp as cycles since reset.
    typedef struct {
        int unsigned ts;
        int unsigned fr;
        int unsigned to;
    } rec_t;

    rec_t        mq[$];
    int unsigned m_cyc;
    bit          m_primed;
    int unsigned m_prev;
    int unsigned m_drop;
    bit          m_ovf;
    int unsigned last_st;
    int          n_cmp;
    int          n_fail;

    task automatic model_step();
        int unsigned occ;
        bit          pop;
        bit          req;
        rec_t        r;
        if (srst) begin
            m_cyc    = 0;
            m_primed = 0;
            m_prev   = 0;
            mq.delete();
            m_drop   = 0;
            m_ovf    = 0;
        end else begin
            occ = mq.size();
            pop = (occ > 0) && evt_ready;
            req = m_primed && state_valid && (int'(state_in) != m_prev);
            if (pop) void'(mq.pop_front());
            if (req) begin
                if (occ < DEPTH || pop) begin
                    r.ts = m_cyc % TS_MOD;
                    r.fr = m_prev;
                    r.to = int'(state_in);
                    mq.push_back(r);
                end else begin
                    if (m_drop < DROP_MAX) m_drop++;
                    m_ovf = 1;
                end
            end
            if (state_valid) begin
                m_prev   = int'(state_in);
                m_primed = 1;
            end
            m_cyc++;
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled at negedge.
    task automatic tick();
        @(posedge aclk);
        model_step();
        @(negedge aclk);
    endtask

    task automatic drive_state(input int unsigned v);
        state_valid = 1'b1;
        state_in    = STATE_W'(v);
        last_st     = v;
    endtask

    task automatic test_reset();
        srst = 1'b1; state_valid = 1'b0; evt_ready = 1'b0;
        repeat (3) tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        n_cmp++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        srst = 1'b0;
        drive_state(2);
        tick();
        state_valid = 1'b0;
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL prime_valid0: got %b expected 0", evt_valid); end
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL prime_valid1: got %b expected 0", evt_valid); end
        n_cmp++; if (drop_cnt !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL prime_drop: got %0d/%b expected 0/0", drop_cnt, overflow); end
    endtask

    task automatic test_single();
        state_valid = 1'b0; evt_ready = 1'b0;
        for (int i = 0; i < 20 && m_cyc != 10; i++) tick();
        drive_state(5);
        tick();
        state_valid = 1'b0;
        n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", evt_valid); end
        n_cmp++; if (evt_from !== STATE_W'(2)) begin n_fail++; $display("FAIL single_from: got %0d expected 2", evt_from); end
        n_cmp++; if (evt_to !== STATE_W'(5)) begin n_fail++; $display("FAIL single_to: got %0d expected 5", evt_to); end
        n_cmp++; if (evt_ts !== TS_W'(10)) begin n_fail++; $display("FAIL single_ts: got %0d expected 10", evt_ts); end
        n_cmp++; if (evt_id !== 32'(NAME)) begin n_fail++; $display("FAIL single_id: got %0d expected %0d", evt_id, NAME); end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b expected 0", evt_valid); end
    endtask

    task automatic test_backpressure();
        int unsigned ef[$];
        int unsigned et[$];
        int unsigned ets[$];
        int          cnt;
        evt_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                ef.push_back(last_st);
                et.push_back((last_st + 1) % 16);
                ets.push_back(m_cyc % TS_MOD);
            end
            drive_state((last_st + 1) % 16);
            tick();
        end
        state_valid = 1'b0;
        n_cmp++; if (drop_cnt !== DROP_W'(2)) begin n_fail++; $display("FAIL bp_drop: got %0d expected 2", drop_cnt); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b expected 1", overflow); end
        evt_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20 && evt_valid === 1'b1; i++) begin
            if (cnt < 8) begin
                n_cmp++;
                if (evt_from !== STATE_W'(ef[cnt]) || evt_to !== STATE_W'(et[cnt]) || evt_ts !== TS_W'(ets[cnt])) begin
                    n_fail++;
                    $display("FAIL bp_rec%0d: got %0d->%0d@%0d expected %0d->%0d@%0d", cnt, evt_from, evt_to, evt_ts, ef[cnt], et[cnt], ets[cnt]);
                end
            end
            cnt++;
            tick();
        end
        evt_ready = 1'b0;
        n_cmp++; if (cnt != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", cnt); end
    endtask

    task automatic test_full_pop();
        int cnt;
        evt_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive_state((last_st + 1) % 16);
            tick();
        end
        evt_ready = 1'b1;
        drive_state((last_st + 1) % 16);
        tick();
        evt_ready = 1'b0; state_valid = 1'b0;
        n_cmp++; if (drop_cnt !== DROP_W'(2)) begin n_fail++; $display("FAIL fullpop_drop: got %0d expected 2", drop_cnt); end
        evt_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20 && evt_valid === 1'b1; i++) begin
            n_cmp++;
            if (mq.size() == 0 || evt_from !== STATE_W'(mq[0].fr) || evt_to !== STATE_W'(mq[0].to) || evt_ts !== TS_W'(mq[0].ts)) begin
                n_fail++;
                $display("FAIL fullpop_rec%0d: got %0d->%0d@%0d model size %0d", cnt, evt_from, evt_to, evt_ts, mq.size());
            end
            cnt++;
            tick();
        end
        evt_ready = 1'b0;
        n_cmp++; if (cnt != 8) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 8", cnt); end
    endtask

    task automatic test_gap_wrap();
        int unsigned exp_from;
        int unsigned exp_to;
        int unsigned exp_ts;
        state_valid = 1'b0; evt_ready = 1'b0;
        exp_from = last_st;
        repeat (20) tick();
        exp_to = (last_st + 3) % 16;
        exp_ts = m_cyc % TS_MOD;
        drive_state(exp_to);
        tick();
        state_valid = 1'b0;
        n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b expected 1", evt_valid); end
        n_cmp++; if (evt_ts !== TS_W'(exp_ts)) begin n_fail++; $display("FAIL gap_ts: got %0d expected %0d", evt_ts, exp_ts); end
        n_cmp++; if (evt_from !== STATE_W'(exp_from)) begin n_fail++; $display("FAIL gap_from: got %0d expected %0d", evt_from, exp_from); end
        n_cmp++; if (evt_to !== STATE_W'(exp_to)) begin n_fail++; $display("FAIL gap_to: got %0d expected %0d", evt_to, exp_to); end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_state((last_st + 1) % 16);
            tick();
        end
        state_valid = 1'b0;
        n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", evt_valid); end
        srst = 1'b1;
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", evt_valid); end
        n_cmp++; if (drop_cnt !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_drop: got %0d/%b expected 0/0", drop_cnt, overflow); end
        srst = 1'b0;
        drive_state(9);
        tick();
        state_valid = 1'b0;
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_prime: got %b expected 0", evt_valid); end
        drive_state(11);
        tick();
        state_valid = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_from !== STATE_W'(9) || evt_to !== STATE_W'(11) || evt_ts !== TS_W'(2)) begin
            n_fail++;
            $display("FAIL mid_event: got v%b %0d->%0d@%0d expected v1 9->11@2", evt_valid, evt_from, evt_to, evt_ts);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic test_drop_sat();
        evt_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            drive_state((last_st + 1) % 16);
            tick();
        end
        state_valid = 1'b0;
        n_cmp++; if (drop_cnt !== DROP_W'(DROP_MAX)) begin n_fail++; $display("FAIL sat_drop: got %0d expected %0d", drop_cnt, DROP_MAX); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", overflow); end
        srst = 1'b1;
        tick();
        srst = 1'b0;
        n_cmp++; if (drop_cnt !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %0d/%b expected 0/0", drop_cnt, overflow); end
    endtask

    task automatic test_random();
        int unsigned rdy_pct;
        for (int c = 0; c < 3000; c++) begin
            rdy_pct     = ((c / 250) % 2 == 0) ? 80 : 20;
            srst        = ($urandom_range(0, 399) == 0);
            state_valid = ($urandom_range(0, 3) != 0);
            state_in    = STATE_W'($urandom_range(0, 3));
            evt_ready   = ($urandom_range(0, 99) < rdy_pct);
            tick();
            n_cmp++;
            if (evt_valid !== (mq.size() > 0)) begin
                n_fail++;
                $display("FAIL rnd_valid c%0d: got %b expected %0d", c, evt_valid, mq.size() > 0);
            end else if (mq.size() > 0) begin
                n_cmp++;
                if (evt_from !== STATE_W'(mq[0].fr) || evt_to !== STATE_W'(mq[0].to) || evt_ts !== TS_W'(mq[0].ts) || evt_id !== 32'(NAME)) begin
                    n_fail++;
                    $display("FAIL rnd_rec c%0d: got %0d->%0d@%0d id%0d expected %0d->%0d@%0d id%0d", c, evt_from, evt_to, evt_ts, evt_id, mq[0].fr, mq[0].to, mq[0].ts, NAME);
                end
            end
            n_cmp++;
            if (drop_cnt !== DROP_W'(m_drop) || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rnd_drop c%0d: got %0d/%b expected %0d/%b", c, drop_cnt, overflow, m_drop, m_ovf);
            end
        end
        srst = 1'b0; state_valid = 1'b0; evt_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        m_cyc = 0; m_primed = 0; m_prev = 0; m_drop = 0; m_ovf = 0; last_st = 0;
        srst = 1'b1; state_valid = 1'b0; state_in = '0; evt_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop();
        test_gap_wrap();
        test_reset_mid();
        test_drop_sat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_event_recorder.md
Name: fsm_event_recorder

Overview:
- Sits directly downstream of fsm_example and similar FSMs.
- Samples the FSM's state bus every cycle and detects state transitions.
- Stamps each transition with a free-running cycle counter and buffers it in a small FIFO.
- Presents the records on a valid/ready stream for the logging/reporting sink.

Parameters:
- NAME, 0, integer ID of the observed FSM; echoed on evt_id.
- STATE_W, 4, width of the observed state bus.
- TS_W, 32, timestamp counter width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DROP_W, 8, width of the dropped-event counter.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- srst  in  1  reset, synchronous, active-high.
- state_valid  in  1  state_in is meaningful this cycle.
- state_in  in  STATE_W  current state of the observed FSM.
- evt_valid  out  1  record available.
- evt_ready  in  1  sink accepts the record.
- evt_id  out  32  constant NAME.
- evt_ts  out  TS_W  cycle count at which the transition was sampled.
- evt_from  out  STATE_W  previous state.
- evt_to  out  STATE_W  new state.
- drop_cnt  out  DROP_W  saturating count of events lost to a full FIFO.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- Reset (srst=1 at an edge): ts counter=0, primed=0, prev_state=0, FIFO empty, evt_valid=0, drop_cnt=0, overflow=0. Reset applies mid-operation too; buffered records are discarded.
- Timestamp counter: increments every cycle outside reset and wraps modulo 2^TS_W with no flag.
- Priming: the first cycle with state_valid=1 after reset loads prev_state and sets primed. No event is generated on that cycle.
- Detection: a push request occurs when primed=1, state_valid=1 and state_in!=prev_state.
  - The record is {ts=current counter, from=prev_state, to=state_in}.
  - prev_state updates to state_in on every state_valid cycle, whether or not the push is accepted.
- state_valid=0: no detection, prev_state is held, and the counter keeps running.
- Push acceptance: accepted when the FIFO is not full, or when a pop happens in the same cycle (evt_valid&&evt_ready).
- Drop rule: otherwise the event is dropped, drop_cnt increments (saturating at all-ones) and overflow is set. Only srst clears either.
- Latency: a transition sampled at edge N is visible at the FIFO head no earlier than edge N+1. With the FIFO empty, evt_valid rises in cycle N+1.
- Output stream:
  - evt_valid = FIFO not empty.
  - Payload is the head entry, stable while evt_valid=1 and evt_ready=0.
  - A pop occurs on evt_valid&&evt_ready.
- Simultaneous push and pop: both happen in the same cycle and occupancy is unchanged, including when full. When the FIFO is empty, the new record does not bypass the FIFO; no combinational path from state_in to evt_*.
- FIFO pointers: log2(DEPTH)+1 bits, wrapping naturally. full = MSBs differ and the low bits are equal.
- evt_ready while evt_valid=0: ignored.

Optional Feature:
- Macro: FSM_EVENT_RECORDER_TRACE_EN.
- Defined: each accepted push issues a $display of "[%t] FSM<NAME> <from> -> <to> @ts" using the $timeformat in force. Each drop issues a $display prefixed "WARNING:". Simulation only, no hardware change.
- Undefined: no display statements are compiled; ports and behaviour are identical.

Decomposition:
- fsm_event_pkg holds:
  - the typedef struct packed fsm_event_t {ts, from, to}, parameterised via localparams of defaults;
  - the DEPTH-legality check function clog2_safe.
- Sub-module fsm_event_fifo:
  - synchronous single-clock FIFO of fsm_event_t with push/pop/full/empty;
  - same aclk/srst;
  - the recorder instantiates one.
- Detection, timestamping and drop accounting stay in fsm_event_recorder.

Test Plan:
- Reset then prime: srst high 3 cycles; state_in=2 with state_valid=1 -> no evt_valid, drop_cnt=0, overflow=0.
- Single transition: state 2->5 sampled at ts=10 -> next cycle evt_valid=1, evt_from=2, evt_to=5, evt_ts=10, evt_id=NAME. evt_ready=1 clears evt_valid the following cycle.
- Backpressure and fill: evt_ready=0, drive 10 distinct transitions with DEPTH=8 -> 8 records held in order, drop_cnt=2, overflow=1. Releasing evt_ready drains exactly 8 records in order.
- Full plus simultaneous pop: FIFO full with evt_ready=1 and a new transition in the same cycle -> accepted, no drop, occupancy stays 8.
- Gaps and wrap: TS_W=4; state_valid=0 for 20 cycles, then a transition -> evt_ts equals the counter modulo 16, evt_from equals the last valid state.
- Reset mid-operation: 3 records buffered, assert srst -> evt_valid=0 the next cycle, drop_cnt=0, and the first post-reset sample primes without emitting an event.
